// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a small receive FIFO and a
// CPU-visible data/status register pair.
module uart_rx #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic       re,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       rx,
    output logic       rx_irq
);

    localparam int CPB  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] LAST_BIT  = CW'(CPB - 1);
    localparam logic [CW-1:0] LAST_HALF = CW'(HALF - 1);
    localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          overrun;
    logic          frame_err;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    logic          empty;
    logic          full;
    logic          stop_sample;
    logic          push;
    logic          pop;
    logic          wr;
    logic          ovr_set;
    logic          ferr_set;
    logic          clr;
    logic          data_in_unused;

    assign empty       = (count == '0);
    assign full        = (count == FULL_CNT);
    assign stop_sample = (state == STOP) && (cnt == LAST_BIT);
    assign push        = stop_sample && rx_sync;
    assign ferr_set    = stop_sample && !rx_sync;
    assign pop         = re && cs && (addr == 8'h00) && !empty;
    assign wr          = push && (!full || pop);
    assign ovr_set     = push && full && !pop;
    assign clr         = cs && we && (addr == 8'h01);
    assign rx_irq      = !empty;

    // The written value carries no meaning; any write clears the flags.
    assign data_in_unused = ^data_in;

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Receiver FSM: start-bit qualification, mid-bit sampling, stop check.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == LAST_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST_BIT) begin
                        cnt   <= '0;
                        shift <= {rx_sync, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == LAST_BIT) begin
                        cnt   <= '0;
                        state <= rx_sync ? IDLE : WAIT_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_sync) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[tail] <= shift;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (wr && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !wr) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (clr) begin
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end
            if (ferr_set) begin
                frame_err <= 1'b1;
            end
        end
    end

    // Register read mux.
    always_comb begin
        data_out = 8'h00;
        if (addr == 8'h00) begin
            data_out = empty ? 8'h00 : mem[head];
        end else if (addr == 8'h01) begin
            data_out = {4'b0, full, frame_err, overrun, !empty};
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames into uart_rx and checks the register
// view against a queue-based model of the receiver and FIFO.
module tb_uart_rx;

    localparam int CLK_FREQ = 1600;
    localparam int BAUD     = 100;
    localparam int DEPTH    = 4;
    localparam int CPB      = CLK_FREQ / BAUD;

    logic       clk;
    logic       rst;
    logic       cs;
    logic       we;
    logic       re;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       rx;
    logic       rx_irq;

    int checks;
    int errors;

    logic [7:0] q[$];
    logic       m_ov;
    logic       m_fe;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic       rd;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    uart_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD_RATE(BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cs(cs),
        .we(we),
        .re(re),
        .addr(addr),
        .data_in(data_in),
        .data_out(data_out),
        .rx(rx),
        .rx_irq(rx_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mstat();
        logic f;
        logic n;
        f = (q.size() == DEPTH);
        n = (q.size() != 0);
        return {4'b0, f, m_fe, m_ov, n};
    endfunction

    function automatic void m_push(input logic [7:0] b);
        if (q.size() == DEPTH) m_ov = 1'b1;
        else q.push_back(b);
    endfunction

    function automatic void m_reset();
        q.delete();
        m_ov = 1'b0;
        m_fe = 1'b0;
    endfunction

    task automatic chk(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic p,
                      output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1;
        addr = a;
        re = p;
        #1 d = data_out;
        @(negedge clk);
        cs = 1'b0;
        re = 1'b0;
        addr = 8'h00;
    endtask

    task automatic clear_flags();
        @(negedge clk);
        cs = 1'b1;
        we = 1'b1;
        addr = 8'h01;
        data_in = 8'($urandom);
        @(negedge clk);
        cs = 1'b0;
        we = 1'b0;
        addr = 8'h00;
        m_ov = 1'b0;
        m_fe = 1'b0;
    endtask

    task automatic chk_status(input string name);
        logic [7:0] d;
        rd(8'h01, 1'b0, d);
        chk(name, d, mstat());
        chk({name, "_irq"}, 8'(rx_irq), 8'(q.size() != 0));
    endtask

    task automatic pop_chk(input string name);
        logic [7:0] d;
        logic [7:0] e;
        e = (q.size() != 0) ? q.pop_front() : 8'h00;
        rd(8'h00, 1'b1, d);
        chk(name, d, e);
    endtask

    // Start bit, 8 data bits LSB first, stop bit; line left at stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx = b[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        rx = stop;
        repeat (CPB - 1) @(negedge clk);
        if (stop) begin
            repeat (4) @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] b;
        logic       bad;
        int         n;

        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        cs      = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        addr    = 8'h00;
        data_in = 8'h00;
        rx      = 1'b1;
        m_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;

        vecs[0] = '{"rst_data", 8'h00, 1'b0, 8'h00};
        vecs[1] = '{"rst_pop_empty", 8'h00, 1'b1, 8'h00};
        vecs[2] = '{"rst_status", 8'h01, 1'b0, 8'h00};
        vecs[3] = '{"rst_off02", 8'h02, 1'b0, 8'h00};
        vecs[4] = '{"rst_off80", 8'h80, 1'b1, 8'h00};
        vecs[5] = '{"rst_offff", 8'hFF, 1'b0, 8'h00};
        for (int i = 0; i < 6; i++) begin
            rd(vecs[i].a, vecs[i].rd, d);
            chk(vecs[i].name, d, vecs[i].exp);
        end
        chk("rst_irq", 8'(rx_irq), 8'h00);

        // Single byte: push lands exactly on the stop-bit sample edge.
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(negedge clk);
                addr = 8'h01;
                repeat (154) @(negedge clk);
                #1 chk("a5_pre_stop", data_out, 8'h00);
                @(negedge clk);
                #1 chk("a5_post_stop", data_out, 8'h01);
                chk("a5_irq", 8'(rx_irq), 8'h01);
                addr = 8'h00;
            end
        join
        m_push(8'hA5);
        pop_chk("a5_data");
        chk_status("a5_empty");

        // Overrun: five bytes into a four-deep FIFO.
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            m_push(8'(i));
        end
        rd(8'h01, 1'b0, d);
        chk("ovr_status", d, 8'h0B);
        for (int i = 0; i < 4; i++) pop_chk("ovr_pop");
        clear_flags();
        chk_status("ovr_clear");

        // Framing error with the line held low afterwards.
        send_frame(8'h3C, 1'b0);
        m_fe = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk_status("fe_low");
        rx = 1'b1;
        repeat (8) @(negedge clk);
        send_frame(8'h7E, 1'b1);
        m_push(8'h7E);
        chk_status("fe_then_7e");
        pop_chk("fe_7e_data");
        clear_flags();

        // Short glitch is rejected as a start bit.
        @(negedge clk);
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk_status("glitch");

        // Full FIFO with a pop on the stop-bit sample edge.
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h11 * 8'(i + 1), 1'b1);
            m_push(8'h11 * 8'(i + 1));
        end
        fork
            send_frame(8'h55, 1'b1);
            begin
                @(negedge clk);
                repeat (154) @(negedge clk);
                cs = 1'b1;
                addr = 8'h00;
                re = 1'b1;
                #1 d = data_out;
                @(negedge clk);
                cs = 1'b0;
                re = 1'b0;
            end
        join
        chk("ovl_pop_data", d, q.pop_front());
        q.push_back(8'h55);
        chk_status("ovl_status");
        for (int i = 0; i < 4; i++) pop_chk("ovl_drain");

        // Reset in the middle of the data bits of 8'hFF.
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reset();
        repeat (8 * CPB) @(negedge clk);
        chk_status("midrst_status");
        send_frame(8'h42, 1'b1);
        m_push(8'h42);
        pop_chk("midrst_42");

        // Random frames, framing errors, pops and clears vs. the model.
        for (int k = 0; k < 24; k++) begin
            b = 8'($urandom);
            bad = ($urandom_range(0, 6) == 0);
            if (bad) begin
                send_frame(b, 1'b0);
                m_fe = 1'b1;
                repeat ($urandom_range(0, 20)) @(negedge clk);
                rx = 1'b1;
                repeat (4) @(negedge clk);
            end else begin
                send_frame(b, 1'b1);
                m_push(b);
            end
            chk_status("rnd_status");
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) pop_chk("rnd_pop");
            if ($urandom_range(0, 3) == 0) begin
                clear_flags();
                chk_status("rnd_clear");
            end
        end
        while (q.size() != 0) pop_chk("rnd_drain");
        chk_status("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 25000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, 2..16.
REQ-004 clk  input  1  system clock (25 MHz); all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cs  input  1  register select from address decoder (UART page $C0xx).
REQ-007 we  input  1  write strobe, already qualified with the CPU clock enable.
REQ-008 re  input  1  read strobe, already qualified with the CPU clock enable; one pulse per CPU read.
REQ-009 addr  input  8  register offset within UART page.
REQ-010 data_in  input  8  CPU write data.
REQ-011 data_out  output  8  register read data, combinational from addr and state.
REQ-012 rx  input  1  asynchronous serial input, idle high.
REQ-013 rx_irq  output  1  high while the FIFO is non-empty.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer reset to 1; all decoding SHALL use the synchronized value.
REQ-015 Bit period SHALL be CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division; 2604 at defaults); half period = CLKS_PER_BIT/2 (1302).
REQ-016 Receiver FSM states: IDLE, START, DATA, STOP, WAIT_IDLE; reset state IDLE.
REQ-017 IDLE: on synchronized rx = 0, go to START and clear the bit-period counter.
REQ-018 START: after half period, if rx = 0 go to DATA, otherwise (glitch) return to IDLE with no flag change.
REQ-019 DATA: sample rx every full period from the start-bit midpoint; 8 bits, LSB first, into the shift register; after bit 7 go to STOP.
REQ-020 STOP: sample rx one full period after bit 7; if 1, push the byte and go to IDLE; if 0, discard the byte, set the framing-error flag, and go to WAIT_IDLE.
REQ-021 WAIT_IDLE: remain until rx = 1, then go to IDLE.
REQ-022 Push SHALL occur in the single clock cycle in which the stop bit is sampled.
REQ-023 FIFO: circular buffer with head/tail pointers wrapping modulo FIFO_DEPTH, plus a count of 0..FIFO_DEPTH.
REQ-024 Push when the FIFO is full and there is no same-cycle pop: byte dropped, FIFO unchanged, overrun flag set.
REQ-025 Push and pop in the same cycle: both SHALL succeed, including when the FIFO is full; count unchanged; no overrun.
REQ-026 Pop SHALL occur on re && cs && addr == 8'h00 while the FIFO is non-empty; a pop when empty has no effect.
REQ-027 Read map, offset 8'h00: head byte, or 8'h00 when empty.
REQ-028 Read map, offset 8'h01 (status): bit0 = not empty, bit1 = overrun, bit2 = framing error, bit3 = full, bits7:4 = 0.
REQ-029 Read map, other offsets: 8'h00.
REQ-030 Any write (cs && we && addr == 8'h01) SHALL clear the overrun and framing flags; data_in is ignored; other writes are ignored.
REQ-031 A flag set and a clear in the same cycle: the set wins.
REQ-032 Status reads SHALL NOT modify state; reading offset 8'h00 without re SHALL NOT pop.
REQ-033 rx_irq = status bit0, combinational from count.

Reset
REQ-034 rst SHALL force: FSM to IDLE; counters, shift register, pointers and count to 0; flags to 0; synchronizer flops to 1.
REQ-035 After reset: data_out = 8'h00 for every offset, rx_irq = 0.
REQ-036 rst mid-frame SHALL abandon the frame with no push and no flag set; reception SHALL resume on the next falling edge after rst deasserts.

Verification
REQ-037 Send 8'hA5 (8N1, 9600 baud) -> stop-bit sample cycle +1: status = 8'h01, rx_irq = 1; re at offset 0 reads 8'hA5; then status = 8'h00.
REQ-038 Send 5 bytes 8'h01..8'h05 with no reads (FIFO_DEPTH = 4) -> status = 8'h0B; pops return 01, 02, 03, 04; after the clear-write, status = 8'h00.
REQ-039 Frame 8'h3C with stop bit 0 and rx held low for 3 bit periods -> no push, status = 8'h04; subsequent valid 8'h7E is received only after rx returns high.
REQ-040 0.4-bit-period low pulse on idle rx -> FSM returns to IDLE, status stays 8'h00.
REQ-041 FIFO full, stop-bit sample coinciding with a pop -> popped byte is the oldest, count stays 4, overrun = 0.
REQ-042 rst asserted at mid-DATA of 8'hFF -> status = 8'h00 after reset; the next frame 8'h42 is received correctly.
